// File: rtl/lane_scroller_pkg.sv
// lane_pkg: shared constants, direction enum and level/LFSR helpers for lane_scroller
package lane_pkg;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_e;
   function automatic int level_period(input logic [3:0] level, input int period1);
      return level == 4'b0010 ? period1 >> 1 :
             level == 4'b0100 ? period1 >> 2 :
             level == 4'b1000 ? period1 >> 3 : period1;
   endfunction
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/lane_scroller_if.sv
// lane_scroller_if: lane configuration, row-load and field-output bundle
interface lane_scroller_if #(parameter int ROWS = 16, parameter int COLS = 16, parameter int DIV_W = 3);
   logic                    pause;
   logic [3:0]              level;
   logic [ROWS*COLS-1:0]    init_field;
   logic [ROWS-1:0]         lane_dir;
   logic [ROWS-1:0]         lane_wrap;
   logic [ROWS*DIV_W-1:0]   lane_div;
   logic                    load_valid;
   logic [$clog2(ROWS)-1:0] load_row;
   logic [COLS-1:0]         load_data;
   logic [ROWS*COLS-1:0]    field;
   logic [ROWS-1:0]         moved;
   logic                    tick;
   modport master (output pause, level, init_field, lane_dir, lane_wrap, lane_div,
                   load_valid, load_row, load_data, input field, moved, tick);
   modport slave (input pause, level, init_field, lane_dir, lane_wrap, lane_div,
                  load_valid, load_row, load_data, output field, moved, tick);
endinterface

// File: rtl/lane_scroller_tick_gen.sv
// lane_tick_gen: level-scaled base counter producing the shift strobe and registered tick
module lane_tick_gen
   import lane_pkg::*;
#(
   parameter int PERIOD1 = 25_000_000,
   parameter int CNT_W = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       resetField,
   input  logic       pause,
   input  logic [3:0] level,
   output logic       fire,
   output logic       tick
);
   logic [CNT_W-1:0] cnt_q, cnt_d, lim;
   logic tick_q, tick_d;
   // >= lets a drop to a shorter period fire at once instead of wrapping the counter
   always_comb begin
      lim = CNT_W'(level_period(level, PERIOD1) - 1);
      fire = !pause && cnt_q >= lim;
      cnt_d = pause ? cnt_q : fire ? '0 : cnt_q + 1'b1;
      tick_d = fire;
   end
   always_ff @(posedge clk) begin
      if (reset || resetField) begin
         cnt_q <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tick_q <= tick_d;
      end
   end
   assign tick = tick_q;
endmodule

// File: rtl/lane_scroller.sv
// lane_scroller: hazard field with independently scrolling lanes, LFSR spawning and row loads
module lane_scroller
   import lane_pkg::*;
#(
   parameter int ROWS = 16,
   parameter int COLS = 16,
   parameter int PERIOD1 = 25_000_000,
   parameter int CNT_W = 25,
   parameter int DIV_W = 3
) (
   input logic            clk,
   input logic            reset,
   input logic            resetField,
   lane_scroller_if.slave bus
);
   localparam int RW = $clog2(ROWS);
   logic fire;
   logic [ROWS*COLS-1:0] field_q, field_d;
   logic [ROWS-1:0] moved_q, moved_d;
   logic [DIV_W-1:0] div_q [ROWS];
   logic [DIV_W-1:0] div_d [ROWS];
   logic [15:0] lfsr_q, lfsr_d;
   lane_tick_gen #(.PERIOD1(PERIOD1), .CNT_W(CNT_W)) u_tick (
      .clk, .reset, .resetField, .pause(bus.pause), .level(bus.level), .fire, .tick(bus.tick)
   );
   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic [COLS-1:0] row, row_d;
      logic in_bit, shift, load, dn;
      // a load on the shifting row wins, but the lane divider still advances
      always_comb begin
         row = field_q[r*COLS +: COLS];
         dn = dir_e'(bus.lane_dir[r]) == DIR_DN;
         shift = fire && div_q[r] >= bus.lane_div[r*DIV_W +: DIV_W];
         load = bus.load_valid && !bus.pause && bus.load_row == RW'(r);
         in_bit = !bus.lane_wrap[r] ? lfsr_q[r % 16] : dn ? row[0] : row[COLS-1];
         row_d = load ? bus.load_data : !shift ? row :
                 dn ? {in_bit, row[COLS-1:1]} : {row[COLS-2:0], in_bit};
      end
      assign field_d[r*COLS +: COLS] = row_d;
      assign moved_d[r] = shift && !load;
      assign div_d[r] = !fire ? div_q[r] : shift ? '0 : div_q[r] + 1'b1;
   end
   always_comb lfsr_d = fire ? lfsr_next(lfsr_q) : lfsr_q;
   always_ff @(posedge clk) begin
      if (reset || resetField) begin
         field_q <= bus.init_field;
         moved_q <= '0;
         div_q <= '{default: '0};
      end else begin
         field_q <= field_d;
         moved_q <= moved_d;
         div_q <= div_d;
      end
      lfsr_q <= reset ? LFSR_SEED : resetField ? lfsr_q : lfsr_d;
   end
   assign bus.field = field_q;
   assign bus.moved = moved_q;
endmodule

// File: doc/lane_scroller.md
# lane_scroller

Parametrised traffic/log lane engine for the Frogger playfield. It owns the ROWS×COLS hazard field and scrolls each lane independently, with per-lane direction, speed divider and wrap/spawn mode. The global scroll rate is set by the one-hot level. Its output feeds the collision checker and the LED-matrix driver. It also supplies per-lane move strobes, so the frog can ride logs.

## Interface
- ROWS, 16, number of lanes (field rows)
- COLS, 16, lane width in cells
- PERIOD1, 25_000_000, base-tick period in clk cycles at level 1; levels 2/3/4 use PERIOD1>>1, >>2, >>3
- CNT_W, 25, base counter width; must hold PERIOD1-1
- DIV_W, 3, per-lane divider width
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high global reset
- resetField  in  1  synchronous field restart; reloads init_field and clears counters
- pause  in  1  freezes all state: field, counters and LFSR
- level  in  4  one-hot level select; any non-one-hot value behaves as level 1
- init_field  in  ROWS×COLS  pattern loaded on reset or resetField
- lane_dir  in  ROWS  per lane: 0 shifts toward MSB, 1 shifts toward LSB
- lane_wrap  in  ROWS  per lane: 1 rotates the cell that leaves the lane; 0 shifts in the spawn bit
- lane_div  in  ROWS×DIV_W  lane moves once every lane_div+1 base ticks
- load_valid  in  1  single-row overwrite strobe
- load_row  in  $clog2(ROWS)  row index to overwrite
- load_data  in  COLS  pattern written to that row
- field  out  ROWS×COLS  current hazard field
- moved  out  ROWS  one-cycle strobe per lane that shifted
- tick  out  1  one-cycle base-tick strobe

## Operation
- Priority each cycle: reset > resetField > pause > (load, shift).
- reset:
  - field = init_field; base counter = 0; all div_cnt = 0.
  - moved = 0; tick = 0; LFSR = 16'hACE1.
- resetField: same as reset, except the LFSR is not reseeded.
- pause: every register holds. moved and tick are forced to 0.
- Base counter:
  - Increments every cycle.
  - When cnt >= P-1, where P is the current level's period, a base tick fires and cnt is cleared.
  - The >= compare makes a mid-count level change to a shorter period fire on the next cycle, with no wrap through 2^CNT_W.
- On a base tick, for each lane r:
  - If div_cnt[r] >= lane_div[r], lane r shifts and div_cnt[r] is cleared.
  - Otherwise div_cnt[r] increments.
- Shift with dir=0: row <= {row[COLS-2:0], in}. Wrap input is row[COLS-1].
- Shift with dir=1: row <= {in, row[COLS-1:1]}. Wrap input is row[0].
- Spawn input (lane_wrap=0): lfsr[r mod 16], using the LFSR value before its advance on the same tick.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances once per base tick.
  - An all-zero state is never reachable from the seed.
- Load:
  - When load_valid is high and load_row < ROWS, field[load_row] = load_data.
  - On a same-cycle shift of that row, the load wins and moved[load_row] is 0. That lane's div_cnt still updates.
  - load_row >= ROWS is ignored.

## Timing
- All outputs are registered. Field updates are visible one cycle after the tick edge.
- moved[r] is high in the same cycle the shifted row first appears on field.
- tick is high in the same cycle as that field update.
- Lane period = (lane_div+1) × P cycles. Steady-state tick spacing is exactly P cycles.
- resetField asserted for N cycles: the field holds init_field during those cycles, and the first tick comes P cycles after release.
- Reset takes effect mid-pause: pause does not block reset or resetField.

## Structure
- Package lane_pkg:
  - LFSR_SEED and LFSR_TAPS constants.
  - dir_e enum (DIR_UP=0, DIR_DN=1).
  - Function level_period(level, PERIOD1), which decodes one-hot to a shift with level-1 fallback.
- Sub-module lane_tick_gen holds the base counter, level decode, pause gating and tick output.
- The top level holds the field, per-lane dividers, LFSR, load path, and a generate loop per lane.

## Test plan
- Bench config: ROWS=4, COLS=8, PERIOD1=8, level=4'b0001, all lane_div=0, lane_wrap=1, lane_dir=0, init row0=8'b1000_0001.
  - After reset and 8 cycles, tick fires.
  - Next cycle: row0=8'b0000_0011, moved=4'b1111.
- Set lane_div[1]=2: row1 shifts on every 3rd tick only (ticks 3, 6, 9 with 8-cycle spacing). moved[1] is high only on those ticks.
- Set lane_dir[2]=1, init row2=8'b0000_0001: after one tick, row2=8'b1000_0000.
- lane_wrap[3]=0 from reset: after the first tick, row3[0] equals bit 3 of 16'hACE1 (=0). After the second tick, row3[0] equals bit 3 of the advanced LFSR value.
- Combined priority and level check:
  - Assert pause for 20 cycles: no tick, field constant.
  - Release, then switch level to 4'b1000: ticks every 1 cycle.
  - Assert load_valid on row0 during a tick: row0=load_data, moved[0]=0.
- Assert resetField mid-run: the next cycle's field equals init_field, and the LFSR continues from its prior state rather than being reseeded.
